receive: RTL and testbench



---
 rtl/receive.sv | 166 ++++++++++++++++
 tb/tb_receive.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/receive.sv
// UART 8N1 receiver with a 2-flop input synchroniser and mid-bit sampling.
// Define RECEIVE_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module receive #(
    parameter int unsigned wtime = 868
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       UART_RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_error
);

    localparam int unsigned half = wtime >> 1;
    localparam int unsigned cw   = $clog2(wtime);
    localparam logic [cw-1:0] half_m1  = cw'(half - 1);
    localparam logic [cw-1:0] wtime_m1 = cw'(wtime - 1);

`ifdef RECEIVE_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitHigh
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StStop, StWaitHigh
    } state_e;
`endif

    state_e         state_q, state_d;
    logic [1:0]     sync_q;
    logic           rx_s;
    logic [cw-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
`ifdef RECEIVE_PARITY_EN
    logic           perr_q, perr_d;
`endif

    assign rx_s = sync_q[1];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RECEIVE_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], UART_RX};
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef RECEIVE_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef RECEIVE_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == half_m1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = StData;
                        idx_d   = '0;
                    end else begin
                        // Start bit gone high at its midpoint: glitch, not a frame.
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
            StData: begin
                if (cnt_q == wtime_m1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef RECEIVE_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
`ifdef RECEIVE_PARITY_EN
            StParity: begin
                if (cnt_q == wtime_m1) begin
                    cnt_d   = '0;
                    perr_d  = rx_s ^ (^shreg_q);
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
`endif
            StStop: begin
                if (cnt_q == wtime_m1) begin
                    cnt_d = '0;
`ifdef RECEIVE_PARITY_EN
                    if (perr_q) begin
                        ferr_d  = 1'b1;
                        state_d = rx_s ? StIdle : StWaitHigh;
                    end else
`endif
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
            StWaitHigh: begin
                // Hold off on a break so a stuck-low line yields one error only.
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_receive.sv
// Scoreboard bench for receive: random and directed 8N1 frames against a bit-timing model.
module tb_receive;

    localparam int unsigned W = 10;
    localparam int unsigned H = W >> 1;
`ifdef RECEIVE_PARITY_EN
    localparam int unsigned NB = 10;
`else
    localparam int unsigned NB = 9;
`endif

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       UART_RX = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frame_error;

    receive #(.wtime(W)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .UART_RX     (UART_RX),
        .data        (data),
        .valid       (valid),
        .busy        (busy),
        .frame_error (frame_error)
    );

    always #5 CLOCK = ~CLOCK;

    int unsigned cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        logic [7:0]  d;
        int unsigned at;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  last_good = 8'h00;
    int          total = 0;
    int          bad = 0;
    int unsigned c0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic put_bit(input logic b);
        UART_RX = b;
        repeat (W) @(negedge CLOCK);
    endtask

    // Expected outcome is decided from the frame contents alone.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        exp_t e;
        bit   good;
`ifdef RECEIVE_PARITY_EN
        good = stop && !pflip;
`else
        good = stop;
`endif
        e.err = !good;
        e.d   = good ? d : last_good;
        e.at  = cyc + 3 + H + NB * W;
        if (good) last_good = d;
        sbq.push_back(e);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(d[i]);
`ifdef RECEIVE_PARITY_EN
        put_bit((^d) ^ pflip);
`endif
        put_bit(stop);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge CLOCK) begin
        if (valid && frame_error) chk("valid_and_error", 32'd1, 32'd0);
        if (valid || frame_error) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", {30'd0, valid, frame_error}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pulse_kind_err", {31'd0, frame_error}, {31'd0, e.err});
                chk("pulse_data", {24'd0, data}, {24'd0, e.d});
                chk("pulse_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLOCK);
        chk("rst_data", {24'd0, data}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, frame_error}, 32'd0);
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);

        // First frame with busy window checks.
        c0 = cyc;
        fork
            send_frame(8'h67, 1'b1, 1'b0);
            begin
                repeat (2) @(negedge CLOCK);
                chk("busy_before_start", {31'd0, busy}, 32'd0);
                @(negedge CLOCK);
                chk("busy_rise", {31'd0, busy}, 32'd1);
                repeat (H + NB * W - 1) @(negedge CLOCK);
                chk("busy_before_valid", {31'd0, busy}, 32'd1);
                @(negedge CLOCK);
                chk("busy_fall", {31'd0, busy}, 32'd0);
            end
        join
        repeat (2 * W) @(negedge CLOCK);

        // Back-to-back frames.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (2 * W) @(negedge CLOCK);

        // Short low glitch.
        UART_RX = 1'b0;
        repeat (3) @(negedge CLOCK);
        UART_RX = 1'b1;
        chk("glitch_busy_rise", {31'd0, busy}, 32'd1);
        repeat (H) @(negedge CLOCK);
        chk("glitch_busy_fall", {31'd0, busy}, 32'd0);
        repeat (2 * W) @(negedge CLOCK);

        // Bad stop bit followed by a break.
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (30) @(negedge CLOCK);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_data_held", {24'd0, data}, {24'd0, last_good});
        UART_RX = 1'b1;
        repeat (4) @(negedge CLOCK);
        chk("break_busy_fall", {31'd0, busy}, 32'd0);
        repeat (2 * W) @(negedge CLOCK);

        // Reset during bit 4 of 8'h3C; the aborted frame expects no pulse.
        put_bit(1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'(8'h3C >> i));
        UART_RX = 1'b1;
        repeat (H) @(negedge CLOCK);
        RESET = 1'b1;
        last_good = 8'h00;
        @(negedge CLOCK);
        RESET = 1'b0;
        chk("midrst_data", {24'd0, data}, 32'h0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ferr", {31'd0, frame_error}, 32'd0);
        repeat (12 * W) @(negedge CLOCK);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (2 * W) @(negedge CLOCK);

`ifdef RECEIVE_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (W) @(negedge CLOCK);
        send_frame(8'h03, 1'b1, 1'b1);
        repeat (2 * W) @(negedge CLOCK);
`endif

        // Random traffic, including back-to-back and broken frames.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       stop, pflip;
            d     = 8'($urandom);
            stop  = ($urandom_range(0, 4) != 0);
            pflip = ($urandom_range(0, 3) == 0);
            send_frame(d, stop, pflip);
            if (!stop) begin
                repeat ($urandom_range(0, 20)) @(negedge CLOCK);
                UART_RX = 1'b1;
                repeat ($urandom_range(2, 8)) @(negedge CLOCK);
            end else begin
                repeat ($urandom_range(0, W)) @(negedge CLOCK);
            end
        end

        UART_RX = 1'b1;
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge CLOCK);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        repeat (5) @(negedge CLOCK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
